// File: rtl/tile_pkg.sv
// tile_pkg: shared geometry, FSM state and mode encodings for the tile sequencer.
package tile_pkg;
    localparam int TILE_SIZE = 128;
    localparam int FP_WIDTH  = 16;
    localparam int SCAL_LAT  = 3;
    localparam int LEN_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    typedef enum logic {
        MODE_DOT   = 1'b0,
        MODE_SCALE = 1'b1
    } mode_e;

    typedef logic [TILE_SIZE-1:0][FP_WIDTH-1:0] lane_vec_t;
endpackage

// File: rtl/tile_seq_if.sv
// tile_seq_if: command, operand, result and tile-side buses of the tile sequencer.
interface tile_seq_if;
    import tile_pkg::*;

    logic                cmd_valid;
    logic                cmd_ready;
    mode_e               cmd_mode;
    logic [LEN_W-1:0]    cmd_len;
    logic [FP_WIDTH-1:0] cmd_scal;
    logic                in_valid;
    logic                in_ready;
    lane_vec_t           in_vec1;
    lane_vec_t           in_vec2;
    lane_vec_t           t_vec1;
    lane_vec_t           t_vec2;
    logic [FP_WIDTH-1:0] t_scal;
    logic                t_control;
    logic [FP_WIDTH-1:0] t_o_scal;
    lane_vec_t           t_o_vec;
    logic                out_valid;
    logic                out_ready;
    lane_vec_t           out_vec;
    logic                res_valid;
    logic                res_ready;
    logic [FP_WIDTH-1:0] res_data;

    modport master (
        output cmd_valid, cmd_mode, cmd_len, cmd_scal, in_valid, in_vec1, in_vec2,
               out_ready, res_ready, t_o_scal, t_o_vec,
        input  cmd_ready, in_ready, t_vec1, t_vec2, t_scal, t_control,
               out_valid, out_vec, res_valid, res_data
    );

    modport slave (
        input  cmd_valid, cmd_mode, cmd_len, cmd_scal, in_valid, in_vec1, in_vec2,
               out_ready, res_ready, t_o_scal, t_o_vec,
        output cmd_ready, in_ready, t_vec1, t_vec2, t_scal, t_control,
               out_valid, out_vec, res_valid, res_data
    );
endinterface

// File: rtl/tile_seq_fp16_add.sv
// new_fp16_add: combinational binary16 adder, round-to-nearest-even, subnormals handled.
module new_fp16_add (
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [15:0] sum_o
);
    logic [15:0] big, sml;
    logic [4:0]  eb, es, d;
    logic [31:0] shf;
    logic [13:0] mb, ms;
    logic [14:0] s;
    logic [5:0]  ex;
    logic [11:0] r;
    logic        inc;

    always_comb begin
        big = a_i;
        sml = b_i;
        if (b_i[14:0] > a_i[14:0]) begin
            big = b_i;
            sml = a_i;
        end
        eb  = (big[14:10] == 5'd0) ? 5'd1 : big[14:10];
        es  = (sml[14:10] == 5'd0) ? 5'd1 : sml[14:10];
        d   = ((eb - es) > 5'd15) ? 5'd15 : (eb - es);
        // Mantissas carry 3 extra bits (guard/round/sticky) below the LSB
        mb  = {big[14:10] != 5'd0, big[9:0], 3'b000};
        shf = {sml[14:10] != 5'd0, sml[9:0], 3'b000, 18'd0} >> d;
        ms  = shf[31:18] | {13'd0, |shf[17:0]};
        s   = (big[15] == sml[15]) ? ({1'b0, mb} + {1'b0, ms}) : ({1'b0, mb} - {1'b0, ms});
        ex  = {1'b0, eb};
        if (s[14]) begin
            s  = {1'b0, s[14:2], s[1] | s[0]};
            ex = ex + 6'd1;
        end else begin
            for (int i = 0; i < 13; i++) begin
                if (!s[13] && ex > 6'd1) begin
                    s  = s << 1;
                    ex = ex - 6'd1;
                end
            end
        end
        inc = s[2] && (s[1] || s[0] || s[3]);
        r   = {1'b0, s[13:3]} + {11'd0, inc};
        if (r[11]) begin
            r  = r >> 1;
            ex = ex + 6'd1;
        end
        sum_o = {(r == 12'd0) ? 1'b0 : big[15], r[10] ? ex[4:0] : 5'd0, r[9:0]};
        if (r[10] && ex >= 6'd31)
            sum_o = {big[15], 5'h1f, 10'd0};
        if (big[14:10] == 5'h1f) begin
            if (big[9:0] != 10'd0 || (sml[14:10] == 5'h1f && sml[15] != big[15]))
                sum_o = 16'h7e00;
            else
                sum_o = big;
        end
    end
endmodule

// File: rtl/tile_seq.sv
// tile_seq: feeds the 128-lane FP16 tile beat by beat; accumulates dot results or streams scaled beats.
// Define TILE_SEQ_PERF_EN to add the perf_busy / perf_stall counters.
module tile_seq
    import tile_pkg::*;
(
    input logic       clk,
    input logic       rst,
    tile_seq_if.slave bus
`ifdef TILE_SEQ_PERF_EN
    ,
    output logic [31:0] perf_busy,
    output logic [31:0] perf_stall
`endif
);
    state_e              state_q, state_d;
    mode_e               mode_q;
    logic [LEN_W-1:0]    len_q, issued_q, received_q;
    logic [FP_WIDTH-1:0] scal_q, acc_q, acc_sum;
    lane_vec_t           vec1_q, vec2_q;
    logic                stage_v_q;
    logic [SCAL_LAT-1:0] sr_q;
    logic                cmd_fire, in_fire, ret, last_ret;

    assign cmd_fire = bus.cmd_valid && bus.cmd_ready;
    assign in_fire  = bus.in_valid && bus.in_ready;
    assign ret      = sr_q[SCAL_LAT-1];
    assign last_ret = ret && (received_q + LEN_W'(1) == len_q);

    new_fp16_add u_acc_add (
        .a_i   (acc_q),
        .b_i   (bus.t_o_scal),
        .sum_o (acc_sum)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (bus.cmd_valid) begin
                if (bus.cmd_len != '0)              state_d = ST_RUN;
                else if (bus.cmd_mode == MODE_DOT)  state_d = ST_DONE;
            end
            ST_RUN: if (issued_q == len_q) begin
                if (mode_q == MODE_DOT)                 state_d = ST_DRAIN;
                else if (!stage_v_q || bus.out_ready)   state_d = ST_IDLE;
            end
            // Leave on the cycle the final result lands so res_valid follows with no extra bubble
            ST_DRAIN: if (received_q == len_q || last_ret) state_d = ST_DONE;
            ST_DONE:  if (bus.res_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.cmd_ready = 1'b0;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.res_valid = 1'b0;
        case (state_q)
            ST_IDLE: bus.cmd_ready = !rst;
            ST_RUN: begin
                bus.in_ready  = (issued_q != len_q) &&
                                (mode_q == MODE_DOT || !stage_v_q || bus.out_ready);
                bus.out_valid = (mode_q == MODE_SCALE) && stage_v_q;
            end
            ST_DONE: bus.res_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.t_vec1    = vec1_q;
    assign bus.t_vec2    = vec2_q;
    assign bus.t_scal    = scal_q;
    assign bus.t_control = mode_q;
    assign bus.out_vec   = bus.t_o_vec;
    assign bus.res_data  = acc_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q     <= MODE_DOT;
            len_q      <= '0;
            issued_q   <= '0;
            received_q <= '0;
            scal_q     <= '0;
            acc_q      <= '0;
            vec1_q     <= '0;
            vec2_q     <= '0;
            stage_v_q  <= 1'b0;
            sr_q       <= '0;
        end else begin
            if (cmd_fire) begin
                mode_q     <= bus.cmd_mode;
                len_q      <= bus.cmd_len;
                scal_q     <= bus.cmd_scal;
                issued_q   <= '0;
                received_q <= '0;
                acc_q      <= '0;
            end
            if (in_fire) begin
                vec1_q   <= bus.in_vec1;
                vec2_q   <= bus.in_vec2;
                issued_q <= issued_q + LEN_W'(1);
            end
            // Scale beats stay staged until handed off; dot beats occupy the stage for one cycle
            stage_v_q <= in_fire || (mode_q == MODE_SCALE && stage_v_q && !bus.out_ready);
            sr_q      <= {sr_q[SCAL_LAT-2:0], stage_v_q && mode_q == MODE_DOT};
            if (ret) begin
                acc_q      <= (received_q == '0) ? bus.t_o_scal : acc_sum;
                received_q <= received_q + LEN_W'(1);
            end
        end
    end

`ifdef TILE_SEQ_PERF_EN
    logic [31:0] busy_q, stall_q;
    logic        stall;

    assign stall = (state_q == ST_RUN) &&
                   ((mode_q == MODE_DOT) ? !bus.in_valid : (bus.out_valid && !bus.out_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q  <= '0;
            stall_q <= '0;
        end else begin
            if (state_q != ST_IDLE && busy_q != '1) busy_q  <= busy_q + 32'd1;
            if (stall && stall_q != '1)             stall_q <= stall_q + 32'd1;
        end
    end

    assign perf_busy  = busy_q;
    assign perf_stall = stall_q;
`endif
endmodule

// File: tb/tb_tile_seq.sv
// tb_tile_seq: directed bench for tile_seq with a small behavioural tile attached.
module tb_tile_seq;
    import tile_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    tile_seq_if bus();
`ifdef TILE_SEQ_PERF_EN
    logic [31:0] perf_busy, perf_stall;
`endif

    tile_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef TILE_SEQ_PERF_EN
        ,
        .perf_busy  (perf_busy),
        .perf_stall (perf_stall)
`endif
    );

    always #5 clk = ~clk;

    // Behavioural tile: dot result after 3 register stages, elementwise scale combinational
    function automatic logic [15:0] tile_dot(input lane_vec_t a, input lane_vec_t b);
        if (a[0] == 16'h3c00 && b[0] == 16'h3c00) return 16'h5800;
        if (a[0] == 16'h4000 && b[0] == 16'h3c00) return 16'h5c00;
        return 16'h0000;
    endfunction

    logic [15:0] dot_p0, dot_p1, dot_p2;
    always @(posedge clk) begin
        dot_p0 <= tile_dot(bus.t_vec1, bus.t_vec2);
        dot_p1 <= dot_p0;
        dot_p2 <= dot_p1;
    end
    assign bus.t_o_scal = dot_p2;

    always_comb begin
        bus.t_o_vec = '0;
        for (int i = 0; i < TILE_SIZE; i++)
            bus.t_o_vec[i] = (bus.t_vec1[i] == 16'h3c00) ? bus.t_scal : 16'h7e00;
    end

    function automatic lane_vec_t fill(input logic [15:0] x);
        lane_vec_t v;
        for (int i = 0; i < TILE_SIZE; i++) v[i] = x;
        return v;
    endfunction

    function automatic logic all_eq(input lane_vec_t v, input logic [15:0] x);
        logic ok;
        ok = 1'b1;
        for (int i = 0; i < TILE_SIZE; i++) if (v[i] !== x) ok = 1'b0;
        return ok;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst           = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_mode  = MODE_DOT;
        bus.cmd_len   = '0;
        bus.cmd_scal  = '0;
        bus.in_valid  = 1'b0;
        bus.in_vec1   = '0;
        bus.in_vec2   = '0;
        bus.out_ready = 1'b0;
        bus.res_ready = 1'b0;

        // Reset state
        step(); step(); look();
        chk("rst_cmd_ready", bus.cmd_ready, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 16'h0000);
        chk("rst_t_scal", bus.t_scal, 16'h0000);
        chk("rst_t_control", bus.t_control, 0);
        chk("rst_t_vec1", all_eq(bus.t_vec1, 16'h0000), 1);
        step(); rst = 1'b0; look();
        chk("idle_cmd_ready", bus.cmd_ready, 1);

        // Dot, len=1, all ones: 128.0 five cycles after acceptance
        step(); bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_DOT; bus.cmd_len = 16'd1; look();
        chk("t1_cmd_ready", bus.cmd_ready, 1);
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1;
        bus.in_vec1 = fill(16'h3c00); bus.in_vec2 = fill(16'h3c00); look();
        chk("t1_in_ready", bus.in_ready, 1);
        chk("t1_t_control", bus.t_control, 0);
        for (int i = 1; i <= 5; i++) begin
            step(); bus.in_valid = 1'b0; look();
            if (i == 1) begin
                chk("t1_t_vec1", all_eq(bus.t_vec1, 16'h3c00), 1);
                chk("t1_in_ready_off", bus.in_ready, 0);
            end
            chk("t1_res_valid", bus.res_valid, (i == 5));
        end
        chk("t1_res_data", bus.res_data, 16'h5800);
        bus.res_ready = 1'b1;
        step(); bus.res_ready = 1'b0; look();
        chk("t1_res_clear", bus.res_valid, 0);
        chk("t1_cmd_ready_back", bus.cmd_ready, 1);

        // Dot, len=2 back to back: 256.0
        step(); bus.cmd_valid = 1'b1; bus.cmd_len = 16'd2; look();
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; look();
        chk("t2_in_ready_b1", bus.in_ready, 1);
        step(); look();
        chk("t2_in_ready_b2", bus.in_ready, 1);
        for (int i = 1; i <= 5; i++) begin
            step(); bus.in_valid = 1'b0; look();
            chk("t2_res_valid", bus.res_valid, (i == 5));
        end
        chk("t2_res_data", bus.res_data, 16'h5c00);
        bus.res_ready = 1'b1;
        step(); bus.res_ready = 1'b0; look();

        // Dot, len=2 with a gap: 128.0 + 256.0 = 384.0
        step(); bus.cmd_valid = 1'b1; bus.cmd_len = 16'd2; look();
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_vec1 = fill(16'h3c00); look();
        step(); bus.in_valid = 1'b0; look();
        chk("t2b_in_ready_gap", bus.in_ready, 1);
        step(); bus.in_valid = 1'b1; bus.in_vec1 = fill(16'h4000); look();
        for (int i = 1; i <= 5; i++) begin
            step(); bus.in_valid = 1'b0; look();
            chk("t2b_res_valid", bus.res_valid, (i == 5));
        end
        chk("t2b_res_data", bus.res_data, 16'h5e00);
        bus.res_ready = 1'b1;
        step(); bus.res_ready = 1'b0; look();

        // Dot, len=0: zero result one cycle after command
        step(); bus.cmd_valid = 1'b1; bus.cmd_len = 16'd0; look();
        step(); bus.cmd_valid = 1'b0; look();
        chk("t4_res_valid", bus.res_valid, 1);
        chk("t4_res_data", bus.res_data, 16'h0000);
        chk("t4_in_ready", bus.in_ready, 0);
        bus.res_ready = 1'b1;
        step(); bus.res_ready = 1'b0; look();
        chk("t4_cmd_ready", bus.cmd_ready, 1);

        // Reset two cycles after a dot beat is accepted, then a clean len=1
        step(); bus.cmd_valid = 1'b1; bus.cmd_len = 16'd1; look();
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1;
        bus.in_vec1 = fill(16'h4000); bus.in_vec2 = fill(16'h3c00); look();
        step(); bus.in_valid = 1'b0; look();
        step(); rst = 1'b1; look();
        chk("t5_cmd_ready_in_rst", bus.cmd_ready, 0);
        step(); rst = 1'b0; look();
        chk("t5_idle", bus.cmd_ready, 1);
        chk("t5_res_valid", bus.res_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step(); look();
            chk("t5_no_res", bus.res_valid, 0);
            chk("t5_no_out", bus.out_valid, 0);
        end
        step(); bus.cmd_valid = 1'b1; bus.cmd_len = 16'd1; look();
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1; bus.in_vec1 = fill(16'h3c00); look();
        for (int i = 1; i <= 5; i++) begin
            step(); bus.in_valid = 1'b0; look();
            chk("t5_res_valid_new", bus.res_valid, (i == 5));
        end
        chk("t5_res_data", bus.res_data, 16'h5800);
        bus.res_ready = 1'b1;
        step(); bus.res_ready = 1'b0; look();

        // Scale, len=3, two-cycle stall on beat 2 (fresh reset clears perf counters)
        step(); rst = 1'b1; look();
        step(); rst = 1'b0; look();
        step(); bus.cmd_valid = 1'b1; bus.cmd_mode = MODE_SCALE; bus.cmd_len = 16'd3;
        bus.cmd_scal = 16'h4000; bus.out_ready = 1'b1; look();
        step(); bus.cmd_valid = 1'b0; bus.in_valid = 1'b1;
        bus.in_vec1 = fill(16'h3c00); bus.in_vec2 = fill(16'h0001); look();
        chk("t3_in_ready_b1", bus.in_ready, 1);
        chk("t3_out_valid_a", bus.out_valid, 0);
        chk("t3_t_control", bus.t_control, 1);
        chk("t3_t_scal", bus.t_scal, 16'h4000);
        step(); bus.in_vec2 = fill(16'h0002); look();
        chk("t3_out_valid_b1", bus.out_valid, 1);
        chk("t3_out_vec_b1", all_eq(bus.out_vec, 16'h4000), 1);
        chk("t3_tag_b1", bus.t_vec2[0], 16'h0001);
        chk("t3_in_ready_b2", bus.in_ready, 1);
        step(); bus.out_ready = 1'b0; bus.in_vec2 = fill(16'h0003); look();
        chk("t3_out_valid_st1", bus.out_valid, 1);
        chk("t3_in_ready_st1", bus.in_ready, 0);
        chk("t3_tag_st1", bus.t_vec2[0], 16'h0002);
        chk("t3_out_vec_st1", all_eq(bus.out_vec, 16'h4000), 1);
        step(); look();
        chk("t3_out_valid_st2", bus.out_valid, 1);
        chk("t3_in_ready_st2", bus.in_ready, 0);
        chk("t3_tag_st2", bus.t_vec2[0], 16'h0002);
        step(); bus.out_ready = 1'b1; look();
        chk("t3_in_ready_b3", bus.in_ready, 1);
        chk("t3_tag_b2_out", bus.t_vec2[0], 16'h0002);
        step(); bus.in_valid = 1'b0; look();
        chk("t3_out_valid_b3", bus.out_valid, 1);
        chk("t3_tag_b3", bus.t_vec2[0], 16'h0003);
        chk("t3_out_vec_b3", all_eq(bus.out_vec, 16'h4000), 1);
        chk("t3_in_ready_done", bus.in_ready, 0);
        chk("t3_res_valid", bus.res_valid, 0);
        step(); look();
        chk("t3_out_valid_idle", bus.out_valid, 0);
        chk("t3_cmd_ready_idle", bus.cmd_ready, 1);
`ifdef TILE_SEQ_PERF_EN
        chk("perf_stall", perf_stall, 32'd2);
        chk("perf_busy", perf_busy, 32'd6);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
